// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, branch flush,
// data-memory wait with timeout, and a saturating stalled-fetch counter.
module pipe_stall_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_Rt,
    input  logic [4:0]  IF_ID_Rs,
    input  logic [4:0]  IF_ID_Rt,
    input  logic        EX_MEM_MemAccess,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    output logic        en_pc,
    output logic        en_if_id,
    output logic        en_id_ex,
    output logic        en_ex_mem,
    output logic        en_mem_wb,
    output logic        flush_if_id,
    output logic        bubble_id_ex,
    output logic        dmem_req,
    output logic        mem_err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } state_e;

    // Last wait_cnt value tolerated before declaring the memory dead.
    localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

    state_e      r_state;
    state_e      w_state_d;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_d;
    logic [15:0] r_stall_cnt;

    logic        w_mem_stall;
    logic        w_lu_hazard;

    // Hazard detection terms.
    always_comb begin
        w_mem_stall = EX_MEM_MemAccess && !dmem_ack && (r_state != StErr);
        w_lu_hazard = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));
    end

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StRun;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_cnt_d;
        end
    end

    // Next-state logic for the memory-wait FSM.
    always_comb begin
        w_state_d    = r_state;
        w_wait_cnt_d = r_wait_cnt;
        unique case (r_state)
            StRun: begin
                if (w_mem_stall) begin
                    w_state_d    = StMemWait;
                    w_wait_cnt_d = 8'd0;
                end
            end
            StMemWait: begin
                if (!w_mem_stall) begin
                    w_state_d    = StRun;
                    w_wait_cnt_d = 8'd0;
                end else if (r_wait_cnt == LastWait) begin
                    w_state_d = StErr;
                end else begin
                    w_wait_cnt_d = r_wait_cnt + 8'd1;
                end
            end
            StErr: begin
                // Only reset leaves the error state.
                w_state_d = StErr;
            end
            default: begin
                w_state_d    = StRun;
                w_wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Prioritised pipeline controls; rst gates them so reset is seen immediately.
    always_comb begin
        en_pc        = 1'b0;
        en_if_id     = 1'b0;
        en_id_ex     = 1'b0;
        en_ex_mem    = 1'b0;
        en_mem_wb    = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        dmem_req     = 1'b0;
        if (rst && (r_state != StErr)) begin
            dmem_req = EX_MEM_MemAccess;
            if (w_mem_stall) begin
                // Whole pipeline freezes; enables stay 0.
            end else if (branch_taken) begin
                // Wrong-path hazard is irrelevant; flush and bubble instead.
                en_pc        = 1'b1;
                en_if_id     = 1'b1;
                en_id_ex     = 1'b1;
                en_ex_mem    = 1'b1;
                en_mem_wb    = 1'b1;
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end else if (w_lu_hazard) begin
                en_id_ex     = 1'b1;
                en_ex_mem    = 1'b1;
                en_mem_wb    = 1'b1;
                bubble_id_ex = 1'b1;
            end else begin
                en_pc     = 1'b1;
                en_if_id  = 1'b1;
                en_id_ex  = 1'b1;
                en_ex_mem = 1'b1;
                en_mem_wb = 1'b1;
            end
        end
    end

    // Error flag follows the state register directly.
    always_comb begin
        mem_err = (r_state == StErr);
    end

    // Saturating count of cycles in which fetch was held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 16'd0;
        end else if (!en_pc && (r_state != StErr) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
